// File: rtl/exc_request_ctrl.sv
// Exception request controller: prioritises invalid-opcode and external IRQ causes,
// holds Exc/EStatus until ExcAck, pulses Flush, masks requests until ERet.
// Optional macro: EXC_IRQ_SYNC_EN adds a two-flop synchroniser on ExtIRQ.
module exc_request_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       ExtIRQ,
  input  logic       InvalidOp_D,
  input  logic       ERet,
  input  logic       ExcAck,
  output logic       Exc,
  output logic [3:0] EStatus,
  output logic       Flush,
  output logic       InHandler
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HANDLER = 2'd2
  } state_e;

  localparam logic [3:0] CAUSE_INVOP = 4'b0010;
  localparam logic [3:0] CAUSE_IRQ   = 4'b0001;

  state_e     state_q;
  logic       irq_s;
  logic       irq_edge;
  logic       irq_prev_q;
  logic       irq_pend_q;
  logic       exc_q;
  logic       flush_q;
  logic       in_handler_q;
  logic [3:0] estatus_q;

`ifdef EXC_IRQ_SYNC_EN
  logic [1:0] irq_sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_sync_q <= 2'b00;
    end else begin
      irq_sync_q <= {irq_sync_q[0], ExtIRQ};
    end
  end

  assign irq_s = irq_sync_q[1];
`else
  // ExtIRQ is guaranteed synchronous to clk in this build.
  assign irq_s = ExtIRQ;
`endif

  assign irq_edge = irq_s & ~irq_prev_q;

  // NOTE: all state, including the pending bit, uses non-blocking assignments so
  // that every branch below sees the pre-edge values; the later irq_pend_q write
  // in IDLE deliberately overrides the generic edge capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      irq_prev_q   <= 1'b0;
      irq_pend_q   <= 1'b0;
      exc_q        <= 1'b0;
      flush_q      <= 1'b0;
      in_handler_q <= 1'b0;
      estatus_q    <= 4'b0000;
    end else begin
      irq_prev_q <= irq_s;
      flush_q    <= 1'b0;
      if (irq_edge) begin
        irq_pend_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (InvalidOp_D) begin
            state_q   <= REQ;
            exc_q     <= 1'b1;
            flush_q   <= 1'b1;
            estatus_q <= CAUSE_INVOP;
          end else if (irq_pend_q || irq_edge) begin
            state_q    <= REQ;
            exc_q      <= 1'b1;
            flush_q    <= 1'b1;
            estatus_q  <= CAUSE_IRQ;
            irq_pend_q <= 1'b0;
          end
        end

        REQ: begin
          if (ExcAck) begin
            state_q      <= HANDLER;
            exc_q        <= 1'b0;
            in_handler_q <= 1'b1;
          end
        end

        HANDLER: begin
          // ERet wins over a coincident InvalidOp_D; no nesting.
          if (ERet) begin
            state_q      <= IDLE;
            in_handler_q <= 1'b0;
          end
        end

        default: begin
          state_q      <= IDLE;
          exc_q        <= 1'b0;
          in_handler_q <= 1'b0;
        end
      endcase
    end
  end

  assign Exc       = exc_q;
  assign EStatus   = estatus_q;
  assign Flush     = flush_q;
  assign InHandler = in_handler_q;

endmodule

// File: tb/tb_exc_request_ctrl.sv
// Self-checking bench for exc_request_ctrl: directed scenarios plus randomized
// traffic compared against a rule-level reference model.
module tb_exc_request_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       ExtIRQ;
  logic       InvalidOp_D;
  logic       ERet;
  logic       ExcAck;
  logic       Exc;
  logic [3:0] EStatus;
  logic       Flush;
  logic       InHandler;

  int checks   = 0;
  int failures = 0;

  exc_request_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .ExtIRQ     (ExtIRQ),
    .InvalidOp_D(InvalidOp_D),
    .ERet       (ERet),
    .ExcAck     (ExcAck),
    .Exc        (Exc),
    .EStatus    (EStatus),
    .Flush      (Flush),
    .InHandler  (InHandler)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 = no request outstanding, 1 = waiting for ack,
  // 2 = handler running. Cause queue depth is one pending IRQ.
  int         m_mode;
  bit         m_irq_waiting;
  bit         m_last_irq;
  bit [1:0]   m_dly;
  bit         m_exc;
  bit         m_flush;
  bit         m_inh;
  logic [3:0] m_code;

  task automatic model_reset();
    m_mode = 0; m_irq_waiting = 0; m_last_irq = 0; m_dly = 0;
    m_exc = 0; m_flush = 0; m_inh = 0; m_code = 4'b0000;
  endtask

  task automatic model_clk(input bit inv, input bit irq, input bit eret, input bit ack);
    bit seen, rose;
`ifdef EXC_IRQ_SYNC_EN
    seen  = m_dly[1];
    m_dly = {m_dly[0], irq};
`else
    seen = irq;
`endif
    rose       = seen && !m_last_irq;
    m_last_irq = seen;
    m_flush    = 0;
    if (m_mode == 0) begin
      if (inv) begin
        m_mode = 1; m_exc = 1; m_flush = 1; m_code = 4'b0010;
        if (rose) m_irq_waiting = 1;
      end else if (m_irq_waiting || rose) begin
        m_mode = 1; m_exc = 1; m_flush = 1; m_code = 4'b0001;
        m_irq_waiting = 0;
      end
    end else begin
      if (rose) m_irq_waiting = 1;
      if (m_mode == 1 && ack) begin
        m_mode = 2; m_exc = 0; m_inh = 1;
      end else if (m_mode == 2 && eret) begin
        m_mode = 0; m_inh = 0;
      end
    end
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".Exc"},       {3'b0, Exc},       {3'b0, m_exc});
    check({tag, ".EStatus"},   EStatus,           m_code);
    check({tag, ".Flush"},     {3'b0, Flush},     {3'b0, m_flush});
    check({tag, ".InHandler"}, {3'b0, InHandler}, {3'b0, m_inh});
  endtask

  // One clock: drive inputs, clock, advance model, sample #1 after the edge.
  task automatic step(input string tag, input bit inv, input bit irq,
                      input bit eret, input bit ack);
    InvalidOp_D = inv; ExtIRQ = irq; ERet = eret; ExcAck = ack;
    @(posedge clk);
    model_clk(inv, irq, eret, ack);
    #1;
    check_model(tag);
  endtask

  task automatic idle(input string tag, input int n, input bit irq);
    for (int i = 0; i < n; i++) step(tag, 0, irq, 0, 0);
  endtask

  initial begin
    reset = 1'b1; ExtIRQ = 0; InvalidOp_D = 0; ERet = 0; ExcAck = 0;
    model_reset();
    #1;
    check_model("reset_async");
    @(posedge clk); #1;
    reset = 1'b0;

    // Idle after reset
    idle("idle", 5, 0);

    // Invalid opcode request, ack, handler, eret
    step("invop", 1, 0, 0, 0);
    check("invop.code", EStatus, 4'b0010);
    check("invop.flush", {3'b0, Flush}, 4'd1);
    idle("invop_hold", 2, 0);
    check("invop.flush_gone", {3'b0, Flush}, 4'd0);
    step("invop_ack", 0, 0, 0, 1);
    check("invop.inh", {3'b0, InHandler}, 4'd1);
    idle("invop_handler", 6, 0);
    step("invop_eret", 0, 0, 1, 0);
    idle("invop_after", 3, 0);

    // Invalid opcode and IRQ together: opcode first, IRQ after ERet
    step("both", 1, 1, 0, 0);
    check("both.first_code", EStatus, 4'b0010);
    idle("both_hold", 3, 1);
    step("both_ack", 0, 1, 0, 1);
    idle("both_handler", 3, 1);
    step("both_eret", 0, 1, 1, 0);
    check("both.idle_gap", {3'b0, Exc}, 4'd0);
    step("both_irq", 0, 1, 0, 0);
    check("both.irq_code", EStatus, 4'b0001);
    check("both.irq_exc", {3'b0, Exc}, 4'd1);
    step("both_irq_ack", 0, 1, 0, 1);
    step("both_irq_eret", 0, 1, 1, 0);
    idle("both_done", 4, 1);
    check("both.no_third", {3'b0, Exc}, 4'd0);
    idle("irq_low", 4, 0);

    // Three IRQ pulses inside the handler collapse to one request
    step("multi", 1, 0, 0, 0);
    step("multi_ack", 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step("multi_hi", 0, 1, 0, 0);
      step("multi_lo", 0, 0, 0, 0);
    end
    idle("multi_settle", 3, 0);
    step("multi_eret", 0, 0, 1, 0);
    step("multi_irq", 0, 0, 0, 0);
    check("multi.irq_code", EStatus, 4'b0001);
    step("multi_irq_ack", 0, 0, 0, 1);
    step("multi_irq_eret", 0, 0, 1, 0);
    idle("multi_done", 5, 0);
    check("multi.single", {3'b0, Exc}, 4'd0);

    // Stray ExcAck in IDLE, stray ERet in REQ, ERet beats InvalidOp_D
    step("stray_ack", 0, 0, 0, 1);
    step("stray_req", 1, 0, 0, 0);
    step("stray_eret", 0, 0, 1, 0);
    check("stray.exc_held", {3'b0, Exc}, 4'd1);
    step("stray_real_ack", 0, 0, 0, 1);
    step("eret_vs_inv", 1, 0, 1, 0);
    idle("eret_vs_inv_after", 3, 0);
    check("eret_vs_inv.dropped", {3'b0, Exc}, 4'd0);

    // IRQ latency
`ifdef EXC_IRQ_SYNC_EN
    step("lat_k", 0, 1, 0, 0);
    check("lat.k", {3'b0, Exc}, 4'd0);
    step("lat_k1", 0, 1, 0, 0);
    check("lat.k1", {3'b0, Exc}, 4'd0);
    step("lat_k2", 0, 1, 0, 0);
    check("lat.k2", {3'b0, Exc}, 4'd1);
`else
    step("lat_k", 0, 1, 0, 0);
    check("lat.k", {3'b0, Exc}, 4'd1);
`endif
    step("lat_ack", 0, 1, 0, 1);
    step("lat_eret", 0, 0, 1, 0);
    idle("lat_after", 4, 0);

    // Asynchronous reset mid-REQ with an IRQ pending
    step("rst_req", 1, 1, 0, 0);
    idle("rst_pend", 3, 1);
    ExtIRQ = 0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_model("rst_mid");
    @(posedge clk); #1;
    reset = 1'b0;
    idle("rst_after", 6, 0);

    // Randomized traffic against the model
    begin
      bit irq_lvl = 0;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(7) == 0) irq_lvl = ~irq_lvl;
        step("rand", ($urandom_range(5) == 0), irq_lvl,
             ($urandom_range(3) == 0), ($urandom_range(2) == 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
